// File: rtl/sifive_scope_trace_pkg.sv
`default_nettype none
// ============================================================================
// sifive_scope_trace_pkg
//   Shared types and beat layout for the scope commit tracer.
//   Revision: 1.0
// ============================================================================
package sifive_scope_trace_pkg;

  localparam logic [3:0] OUTST_MAX = 4'd15;

  // Field offsets inside the second trace beat
  localparam int BEAT1_WDATA_LSB = 0;
  localparam int BEAT1_RD_LSB    = 32;
  localparam int BEAT1_WEN_BIT   = 37;
  localparam int BEAT1_EXC_BIT   = 38;
  localparam int BEAT1_PRIV_LSB  = 39;
  localparam int BEAT1_LOST_BIT  = 41;
  localparam int BEAT1_OUTST_LSB = 42;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BEAT0 = 2'd1,
    BEAT1 = 2'd2
  } ser_state_e;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] insn;
    logic [31:0] wdata;
    logic [4:0]  rd;
    logic        wen;
    logic        exc;
    logic [1:0]  priv;
    logic [3:0]  outst;
    logic        lost;
  } commit_rec_t;

  function automatic logic [63:0] beat0_of(input commit_rec_t rec);
    return {rec.insn, rec.pc};
  endfunction

  function automatic logic [63:0] beat1_of(input commit_rec_t rec);
    logic [63:0] b;
    b = '0;
    b[BEAT1_WDATA_LSB +: 32] = rec.wdata;
    b[BEAT1_RD_LSB    +: 5]  = rec.rd;
    b[BEAT1_WEN_BIT]         = rec.wen;
    b[BEAT1_EXC_BIT]         = rec.exc;
    b[BEAT1_PRIV_LSB  +: 2]  = rec.priv;
    b[BEAT1_LOST_BIT]        = rec.lost;
    b[BEAT1_OUTST_LSB +: 4]  = rec.outst;
    return b;
  endfunction

endpackage
`default_nettype wire

// File: rtl/sifive_scope_trace_fifo.sv
`default_nettype none
// ============================================================================
// sifive_scope_trace_fifo
//   DEPTH x WIDTH synchronous FIFO; exposes head and the entry behind it.
//   Revision: 1.0
// ============================================================================
module sifive_scope_trace_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 32
) (
  input  logic                       clock,
  input  logic                       reset_n,
  input  logic                       push,
  input  logic                       pop,
  input  logic [WIDTH-1:0]           wdata,
  output logic [WIDTH-1:0]           rdata,
  output logic [WIDTH-1:0]           rdata_next,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_count;
  logic [AW-1:0]    w_rd_ptr_nxt;

  assign w_rd_ptr_nxt = r_rd_ptr + AW'(1);

  always_ff @(posedge clock) begin
    if (push) begin
      r_mem[r_wr_ptr] <= wdata;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (pop)  r_rd_ptr <= w_rd_ptr_nxt;
      case ({push, pop})
        2'b10:   r_count <= r_count + (AW+1)'(1);
        2'b01:   r_count <= r_count - (AW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign rdata      = r_mem[r_rd_ptr];
  assign rdata_next = r_mem[w_rd_ptr_nxt];
  assign full       = (r_count == (AW+1)'(DEPTH));
  assign empty      = (r_count == '0);
  assign count      = r_count;

endmodule
`default_nettype wire

// File: rtl/sifive_scope_commit_tracer.sv
`default_nettype none
// ============================================================================
// sifive_scope_commit_tracer
//   Buffers hart commit records and streams each as two 64-bit trace beats.
//   Revision: 1.0
// ============================================================================
module sifive_scope_commit_tracer
  import sifive_scope_trace_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int CNT_W = 8
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             trace_en,
  input  logic             commit_valid,
  input  logic [31:0]      commit_pc,
  input  logic [31:0]      commit_insn,
  input  logic             commit_wen,
  input  logic [4:0]       commit_rd,
  input  logic [31:0]      commit_wdata,
  input  logic             commit_exc,
  input  logic [1:0]       commit_priv,
  input  logic             tl_a_fire,
  input  logic             tl_d_fire,
  input  logic             tl_d_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [63:0]      out_data,
  output logic             out_last,
  output logic [CNT_W-1:0] drop_count,
  output logic             overflow
);

  localparam int CW = $clog2(DEPTH) + 1;

  commit_rec_t      w_rec;
  commit_rec_t      w_head;
  commit_rec_t      w_head_next;
  logic             w_capture;
  logic             w_pop;
  logic             w_push;
  logic             w_drop;
  logic             w_full;
  logic             w_empty;
  logic             w_d_done;
  logic [CW-1:0]    w_count;

  logic [3:0]       r_outst;
  logic             r_lost_pending;
  logic [CNT_W-1:0] r_drop_count;
  logic             r_overflow;

  ser_state_e       r_state;
  ser_state_e       w_state_nxt;
  logic [63:0]      r_data;
  logic [63:0]      w_data_nxt;
  logic             r_last;
  logic             w_last_nxt;
  logic             r_valid;

  always_comb begin
    w_rec       = '0;
    w_rec.pc    = commit_pc;
    w_rec.insn  = commit_insn;
    w_rec.wdata = commit_wdata;
    w_rec.rd    = commit_rd;
    w_rec.wen   = commit_wen;
    w_rec.exc   = commit_exc;
    w_rec.priv  = commit_priv;
    w_rec.outst = r_outst;
    w_rec.lost  = r_lost_pending;
  end

  // A pop frees a slot in the same cycle, so full-with-pop still accepts
  assign w_capture = trace_en && commit_valid;
  assign w_pop     = (r_state == BEAT1) && out_ready;
  assign w_push    = w_capture && !(w_full && !w_pop);
  assign w_drop    = w_capture &&  (w_full && !w_pop);
  assign w_d_done  = tl_d_fire && tl_d_last;

  sifive_scope_trace_fifo #(
    .DEPTH (DEPTH),
    .WIDTH ($bits(commit_rec_t))
  ) u_fifo (
    .clock      (clock),
    .reset_n    (reset_n),
    .push       (w_push),
    .pop        (w_pop),
    .wdata      (w_rec),
    .rdata      (w_head),
    .rdata_next (w_head_next),
    .full       (w_full),
    .empty      (w_empty),
    .count      (w_count)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_outst <= '0;
    end else if (tl_a_fire && !w_d_done) begin
      if (r_outst != OUTST_MAX) r_outst <= r_outst + 4'd1;
    end else if (w_d_done && !tl_a_fire) begin
      if (r_outst != 4'd0) r_outst <= r_outst - 4'd1;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_drop_count   <= '0;
      r_overflow     <= 1'b0;
      r_lost_pending <= 1'b0;
    end else begin
      if (w_drop) begin
        if (r_drop_count != {CNT_W{1'b1}}) r_drop_count <= r_drop_count + CNT_W'(1);
        r_overflow     <= 1'b1;
        r_lost_pending <= 1'b1;
      end else if (w_push) begin
        r_lost_pending <= 1'b0;
      end
    end
  end

  // Next beat is preloaded into the output register, bypassing the FIFO
  // when the record being pushed this cycle is the next one to go out.
  always_comb begin
    w_state_nxt = r_state;
    w_data_nxt  = r_data;
    w_last_nxt  = r_last;
    case (r_state)
      IDLE: begin
        if (!w_empty) begin
          w_state_nxt = BEAT0;
          w_data_nxt  = beat0_of(w_head);
          w_last_nxt  = 1'b0;
        end else if (w_push) begin
          w_state_nxt = BEAT0;
          w_data_nxt  = beat0_of(w_rec);
          w_last_nxt  = 1'b0;
        end
      end
      BEAT0: begin
        if (out_ready) begin
          w_state_nxt = BEAT1;
          w_data_nxt  = beat1_of(w_head);
          w_last_nxt  = 1'b1;
        end
      end
      BEAT1: begin
        if (out_ready) begin
          if (w_count > CW'(1)) begin
            w_state_nxt = BEAT0;
            w_data_nxt  = beat0_of(w_head_next);
            w_last_nxt  = 1'b0;
          end else if (w_push) begin
            w_state_nxt = BEAT0;
            w_data_nxt  = beat0_of(w_rec);
            w_last_nxt  = 1'b0;
          end else begin
            w_state_nxt = IDLE;
            w_data_nxt  = '0;
            w_last_nxt  = 1'b0;
          end
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_data_nxt  = '0;
        w_last_nxt  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= IDLE;
      r_data  <= '0;
      r_last  <= 1'b0;
      r_valid <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_data  <= w_data_nxt;
      r_last  <= w_last_nxt;
      r_valid <= (w_state_nxt != IDLE);
    end
  end

  assign out_valid  = r_valid;
  assign out_data   = r_data;
  assign out_last   = r_last;
  assign drop_count = r_drop_count;
  assign overflow   = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_sifive_scope_commit_tracer.sv
`default_nettype none
// ============================================================================
// tb_sifive_scope_commit_tracer
//   Directed and random stimulus against a queue-based reference model.
//   Revision: 1.0
// ============================================================================
module tb_sifive_scope_commit_tracer;

  localparam int DEPTH = 8;
  localparam int CNT_W = 8;
  localparam int DROP_MAX = (1 << CNT_W) - 1;

  logic             clock;
  logic             reset_n;
  logic             trace_en;
  logic             commit_valid;
  logic [31:0]      commit_pc;
  logic [31:0]      commit_insn;
  logic             commit_wen;
  logic [4:0]       commit_rd;
  logic [31:0]      commit_wdata;
  logic             commit_exc;
  logic [1:0]       commit_priv;
  logic             tl_a_fire;
  logic             tl_d_fire;
  logic             tl_d_last;
  logic             out_valid;
  logic             out_ready;
  logic [63:0]      out_data;
  logic             out_last;
  logic [CNT_W-1:0] drop_count;
  logic             overflow;

  sifive_scope_commit_tracer #(
    .DEPTH (DEPTH),
    .CNT_W (CNT_W)
  ) dut (
    .clock        (clock),
    .reset_n      (reset_n),
    .trace_en     (trace_en),
    .commit_valid (commit_valid),
    .commit_pc    (commit_pc),
    .commit_insn  (commit_insn),
    .commit_wen   (commit_wen),
    .commit_rd    (commit_rd),
    .commit_wdata (commit_wdata),
    .commit_exc   (commit_exc),
    .commit_priv  (commit_priv),
    .tl_a_fire    (tl_a_fire),
    .tl_d_fire    (tl_d_fire),
    .tl_d_last    (tl_d_last),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_data     (out_data),
    .out_last     (out_last),
    .drop_count   (drop_count),
    .overflow     (overflow)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%h expected=%h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: queue of expected beat pairs plus scalar bookkeeping
  typedef struct packed {
    logic [63:0] b0;
    logic [63:0] b1;
  } exp_rec_t;

  exp_rec_t mq[$];
  bit       m_half;
  int       m_outst;
  int       m_drops;
  bit       m_ovf;
  bit       m_lostp;

  task automatic model_reset();
    mq.delete();
    m_half  = 0;
    m_outst = 0;
    m_drops = 0;
    m_ovf   = 0;
    m_lostp = 0;
  endtask

  task automatic tick();
    bit       hs;
    bit       pop;
    bit       cap;
    bit       full_eff;
    bit       dl;
    bit       do_push;
    exp_rec_t r;
    hs       = (mq.size() != 0) && out_ready;
    pop      = hs && m_half;
    cap      = trace_en && commit_valid;
    full_eff = (mq.size() == DEPTH) && !pop;
    do_push  = 0;
    r        = '0;
    if (cap && full_eff) begin
      if (m_drops < DROP_MAX) m_drops++;
      m_ovf   = 1;
      m_lostp = 1;
    end else if (cap) begin
      r.b0 = {commit_insn, commit_pc};
      r.b1 = {18'b0, 4'(m_outst), m_lostp, commit_priv, commit_exc, commit_wen,
              commit_rd, commit_wdata};
      do_push = 1;
      m_lostp = 0;
    end
    dl = tl_d_fire && tl_d_last;
    if (tl_a_fire && !dl) begin
      if (m_outst < 15) m_outst++;
    end else if (dl && !tl_a_fire) begin
      if (m_outst > 0) m_outst--;
    end
    @(posedge clock);
    #1;
    if (hs) begin
      if (m_half) begin
        void'(mq.pop_front());
        m_half = 0;
      end else begin
        m_half = 1;
      end
    end
    if (do_push) mq.push_back(r);
    check("valid", {63'b0, out_valid}, {63'b0, mq.size() != 0});
    if (mq.size() != 0) begin
      check("data", out_data, m_half ? mq[0].b1 : mq[0].b0);
      check("last", {63'b0, out_last}, {63'b0, m_half});
    end
    check("drops", 64'(drop_count), 64'(m_drops));
    check("overflow", {63'b0, overflow}, {63'b0, m_ovf});
  endtask

  task automatic rand_commit_fields();
    commit_pc    = $urandom;
    commit_insn  = $urandom;
    commit_wdata = $urandom;
    commit_rd    = 5'($urandom);
    commit_wen   = 1'($urandom);
    commit_exc   = 1'($urandom);
    commit_priv  = 2'($urandom);
  endtask

  task automatic idle_inputs();
    commit_valid = 1'b0;
    tl_a_fire    = 1'b0;
    tl_d_fire    = 1'b0;
    tl_d_last    = 1'b0;
  endtask

  task automatic drain();
    idle_inputs();
    out_ready = 1'b1;
    repeat (2 * DEPTH + 4) tick();
  endtask

  // Capture one record into an empty FIFO and bring its second beat out
  task automatic commit_and_show_beat1();
    rand_commit_fields();
    commit_valid = 1'b1;
    out_ready    = 1'b1;
    tick();
    idle_inputs();
    tick();
  endtask

  initial begin
    reset_n   = 1'b0;
    trace_en  = 1'b0;
    out_ready = 1'b0;
    idle_inputs();
    rand_commit_fields();
    model_reset();
    repeat (2) @(posedge clock);
    #1;
    check("rst_valid", {63'b0, out_valid}, 64'd0);
    check("rst_data", out_data, 64'd0);
    check("rst_last", {63'b0, out_last}, 64'd0);
    check("rst_drops", 64'(drop_count), 64'd0);
    check("rst_overflow", {63'b0, overflow}, 64'd0);
    @(negedge clock);
    reset_n  = 1'b1;
    trace_en = 1'b1;

    // Single commit: beat0 the cycle after, beat1 the cycle after that
    commit_pc    = 32'h8000_0000;
    commit_insn  = 32'h0013_0313;
    commit_wen   = 1'b1;
    commit_rd    = 5'd6;
    commit_wdata = 32'h5;
    commit_exc   = 1'b0;
    commit_priv  = 2'd3;
    commit_valid = 1'b1;
    out_ready    = 1'b1;
    tick();
    check("single_b0", out_data, 64'h0013_0313_8000_0000);
    check("single_b0_last", {63'b0, out_last}, 64'd0);
    idle_inputs();
    tick();
    check("single_b1_wdata", 64'(out_data[31:0]), 64'h5);
    check("single_b1_rd", 64'(out_data[36:32]), 64'd6);
    check("single_b1_wen", 64'(out_data[37]), 64'd1);
    check("single_b1_last", {63'b0, out_last}, 64'd1);
    drain();

    // Fill the FIFO with the sink stalled, then overrun it by three
    out_ready    = 1'b0;
    commit_valid = 1'b1;
    for (int i = 0; i < DEPTH + 3; i++) begin
      rand_commit_fields();
      tick();
    end
    check("fill_drops", 64'(drop_count), 64'd3);
    check("fill_overflow", {63'b0, overflow}, 64'd1);

    // Capture disabled on a full FIFO: nothing counted
    trace_en = 1'b0;
    for (int i = 0; i < 10; i++) begin
      rand_commit_fields();
      tick();
    end
    check("disabled_drops", 64'(drop_count), 64'd3);
    trace_en = 1'b1;
    drain();

    // First record after the overrun carries lost, the next one does not
    commit_and_show_beat1();
    check("lost_first", 64'(out_data[41]), 64'd1);
    tick();
    commit_and_show_beat1();
    check("lost_second", 64'(out_data[41]), 64'd0);
    drain();

    // Outstanding: three A fires, then A and D-last together
    tl_a_fire = 1'b1;
    repeat (3) tick();
    tl_d_fire = 1'b1;
    tl_d_last = 1'b1;
    tick();
    commit_and_show_beat1();
    check("outst_3", 64'(out_data[45:42]), 64'd3);
    tick();

    tl_a_fire = 1'b1;
    repeat (20) tick();
    commit_and_show_beat1();
    check("outst_sat", 64'(out_data[45:42]), 64'd15);
    tick();

    tl_d_fire = 1'b1;
    tl_d_last = 1'b1;
    repeat (20) tick();
    commit_and_show_beat1();
    check("outst_floor", 64'(out_data[45:42]), 64'd0);
    drain();

    // Random traffic
    for (int i = 0; i < 1500; i++) begin
      rand_commit_fields();
      trace_en     = ($urandom_range(0, 9) != 0);
      commit_valid = ($urandom_range(0, 9) < 6);
      out_ready    = ($urandom_range(0, 9) < 5);
      tl_a_fire    = ($urandom_range(0, 9) < 3);
      tl_d_fire    = ($urandom_range(0, 9) < 3);
      tl_d_last    = 1'($urandom);
      tick();
    end
    drain();

    // Reset in the middle of a record with four queued
    out_ready    = 1'b0;
    commit_valid = 1'b1;
    repeat (4) begin
      rand_commit_fields();
      tick();
    end
    idle_inputs();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("pre_rst_last", {63'b0, out_last}, 64'd1);
    #2;
    reset_n = 1'b0;
    #1;
    check("midrst_valid", {63'b0, out_valid}, 64'd0);
    check("midrst_drops", 64'(drop_count), 64'd0);
    check("midrst_data", out_data, 64'd0);
    check("midrst_overflow", {63'b0, overflow}, 64'd0);
    model_reset();
    @(negedge clock);
    reset_n   = 1'b1;
    out_ready = 1'b1;
    repeat (6) tick();
    commit_and_show_beat1();
    tick();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
